// File: rtl/instance5_unit.sv
// Four-lane masked-difference detector: per byte lane, popcount((a^c)&b) >= THRESHOLD sets a flag.
// Latency: 1 edge (inputs at edge N -> d after edge N); 2 edges when INSTANCE5_PIPE_EN is defined.
// Backpressure: none; no handshake or enable, d is recomputed on every clock edge.

// Lane stage 1: positional XOR against the reference byte, then mask.
module instance5_xor_mask (
    input  logic [7:0] lane,
    input  logic [7:0] ref_byte,
    input  logic [7:0] mask,
    output logic [7:0] diff
);
    // Bits that differ from the reference and are enabled by the mask.
    always_comb begin
        diff = (lane ^ ref_byte) & mask;
    end
endmodule

// Lane stage 2: count set bits of an 8-bit vector (0..8, fits in 4 bits).
module instance5_popcount (
    input  logic [7:0] bits,
    output logic [3:0] count
);
    // Simple adder chain; the synthesis tool builds a compressor tree.
    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, bits[i]};
        end
    end
endmodule

// Lane stage 3: threshold compare. THRESHOLD 0 always fires, 9 never fires.
module instance5_compare #(
    parameter int THRESHOLD = 2
) (
    input  logic [3:0] count,
    output logic       flag
);
    // One extra bit so thresholds up to 9 compare without truncation.
    localparam logic [4:0] TH = 5'(THRESHOLD);

    // Flag when the masked mismatch count reaches the threshold.
    always_comb begin
        flag = ({1'b0, count} >= TH);
    end
endmodule

// Top level: four independent lanes, registered flags, optional count pipeline.
// Optional feature macro: INSTANCE5_PIPE_EN (adds a count register stage).
module instance5_unit #(
    parameter int THRESHOLD = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [3:0][7:0] a,
    input  logic [0:7]      b,
    input  logic [7:0]      c,
    output logic [0:3]      d
);
    // b is declared big-endian; a plain assignment realigns it so that
    // mask[7] = b[0] pairs with c[7] and a[i][7] (MSB to MSB).
    logic [7:0]      mask;
    logic [3:0][7:0] diff;
    logic [3:0][3:0] count;
    logic [3:0][3:0] count_use;
    logic [3:0]      flag;

    // Realign the big-endian mask into a little-endian working vector.
    always_comb begin
        mask = b;
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        instance5_xor_mask u_xor_mask (
            .lane     (a[i]),
            .ref_byte (c),
            .mask     (mask),
            .diff     (diff[i])
        );

        instance5_popcount u_popcount (
            .bits  (diff[i]),
            .count (count[i])
        );

        instance5_compare #(
            .THRESHOLD (THRESHOLD)
        ) u_compare (
            .count (count_use[i]),
            .flag  (flag[i])
        );
    end

`ifdef INSTANCE5_PIPE_EN
    logic [3:0][3:0] count_q;

    // Count register stage between popcount and compare; cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count;
        end
    end

    // Compare operates on the registered counts.
    always_comb begin
        count_use = count_q;
    end
`else
    // Compare operates directly on the live counts.
    always_comb begin
        count_use = count;
    end
`endif

    // Output flag register; d[0] (MSB position) carries lane 3.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            d <= 4'b0000;
        end else begin
            d <= {flag[3], flag[2], flag[1], flag[0]};
        end
    end
endmodule

// File: tb/tb_instance5_unit.sv
module tb_instance5_unit;
    typedef int cnt_t [4];

`ifdef INSTANCE5_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clock = 1'b0;
    logic            reset_n;
    logic [3:0][7:0] a;
    logic [0:7]      b;
    logic [7:0]      c;
    logic [0:3]      d;
    logic [0:3]      d_t0;
    logic [0:3]      d_t9;

    int errors = 0;
    int checks = 0;

    // Reference model state
    cnt_t       cnt_q = '{0, 0, 0, 0};
    logic [3:0] exp2, exp0, exp9;

    always #5 clock = ~clock;

    instance5_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d)
    );

    instance5_unit #(.THRESHOLD(0)) dut_t0 (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d_t0)
    );

    instance5_unit #(.THRESHOLD(9)) dut_t9 (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d_t9)
    );

    // Flags as {f3,f2,f1,f0}: lane i fires when its count reaches th.
    function automatic logic [3:0] flags(input cnt_t n, input int th);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (n[i] >= th);
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven,
    // then wait for the edge and settle 1 time unit past it.
    task automatic tick();
        cnt_t       cur;
        cnt_t       src;
        logic [7:0] mk;
        mk = b;
        for (int i = 0; i < 4; i++) cur[i] = $countones((a[i] ^ c) & mk);
`ifdef INSTANCE5_PIPE_EN
        src = cnt_q;
        if (!reset_n) cnt_q = '{0, 0, 0, 0};
        else          cnt_q = cur;
`else
        src = cur;
`endif
        if (!reset_n) begin
            exp2 = 4'b0000; exp0 = 4'b0000; exp9 = 4'b0000;
        end else begin
            exp2 = flags(src, 2); exp0 = flags(src, 0); exp9 = flags(src, 9);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_mixed();
        a = {8'hAC, 8'h96, 8'hF1, 8'hA5};
        b = 8'hE7;
        c = 8'h3C;
    endtask

    task automatic set_zero();
        a = 32'h0; b = 8'h00; c = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = $urandom; b = 8'($urandom); c = 8'($urandom);
            tick();
            checks++;
            if (d !== 4'b0000) begin
                errors++; $display("FAIL reset_th2 edge%0d: got %b want 0000", k, d);
            end
            checks++;
            if (d_t0 !== 4'b0000) begin
                errors++; $display("FAIL reset_th0 edge%0d: got %b want 0000", k, d_t0);
            end
        end
        // First edge after release samples inputs normally.
        reset_n = 1'b1;
        set_mixed();
        tick();
        checks++;
        if (d !== exp2) begin
            errors++; $display("FAIL reset_release_first: got %b want %b", d, exp2);
        end
        checks++;
        if (d_t0 !== exp0) begin
            errors++; $display("FAIL reset_release_first_th0: got %b want %b", d_t0, exp0);
        end
    endtask

    task automatic test_all_zero();
        set_zero();
        for (int k = 0; k < LAT + 1; k++) tick();
        checks++;
        if (d !== 4'b0000) begin
            errors++; $display("FAIL all_zero: got %b want 0000", d);
        end
        checks++;
        if (d_t0 !== 4'b1111) begin
            errors++; $display("FAIL all_zero_th0: got %b want 1111", d_t0);
        end
    endtask

    task automatic test_back_to_back();
        set_mixed();
        for (int k = 0; k < LAT; k++) tick();
        checks++;
        if (d !== 4'b0111) begin
            errors++; $display("FAIL mixed_th2: got %b want 0111", d);
        end
        checks++;
        if (d_t9 !== 4'b0000) begin
            errors++; $display("FAIL mixed_th9: got %b want 0000", d_t9);
        end
        checks++;
        if (d_t0 !== 4'b1111) begin
            errors++; $display("FAIL mixed_th0: got %b want 1111", d_t0);
        end
        set_zero();
        for (int k = 0; k < LAT; k++) tick();
        checks++;
        if (d !== 4'b0000) begin
            errors++; $display("FAIL mixed_then_zero: got %b want 0000", d);
        end
    endtask

    task automatic test_mask_off();
        set_mixed();
        b = 8'h00;
        for (int k = 0; k < LAT; k++) tick();
        checks++;
        if (d !== 4'b0000) begin
            errors++; $display("FAIL mask_off_th2: got %b want 0000", d);
        end
        checks++;
        if (d_t0 !== 4'b1111) begin
            errors++; $display("FAIL mask_off_th0: got %b want 1111", d_t0);
        end
    endtask

    task automatic test_full_mismatch();
        a = 32'hFFFF_FFFF; c = 8'h00; b = 8'hFF;
        for (int k = 0; k < LAT; k++) tick();
        checks++;
        if (d !== 4'b1111) begin
            errors++; $display("FAIL full_th2: got %b want 1111", d);
        end
        checks++;
        if (d_t9 !== 4'b0000) begin
            errors++; $display("FAIL full_th9: got %b want 0000", d_t9);
        end
        // Single-bit mask: count exactly 1 per lane, just below threshold 2.
        b = 8'h80;
        for (int k = 0; k < LAT; k++) tick();
        checks++;
        if (d !== 4'b0000) begin
            errors++; $display("FAIL one_bit_th2: got %b want 0000", d);
        end
    endtask

    task automatic test_latency();
        set_zero();
        tick(); tick();
        set_mixed();
        tick();
        set_zero();
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            checks++;
            if (d !== ((k == LAT) ? 4'b0111 : 4'b0000)) begin
                errors++;
                $display("FAIL latency edge%0d: got %b want %b", k, d,
                         (k == LAT) ? 4'b0111 : 4'b0000);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            reset_n = ($urandom_range(0, 15) != 0);
            a = $urandom;
            b = 8'($urandom);
            c = 8'($urandom);
            if (k % 7 == 0) c = a[$urandom_range(0, 3)] ^ 8'($urandom_range(0, 3));
            tick();
            checks++;
            if (d !== exp2) begin
                errors++; $display("FAIL random_th2 iter%0d: got %b want %b", k, d, exp2);
            end
            checks++;
            if (d_t0 !== exp0) begin
                errors++; $display("FAIL random_th0 iter%0d: got %b want %b", k, d_t0, exp0);
            end
            checks++;
            if (d_t9 !== exp9) begin
                errors++; $display("FAIL random_th9 iter%0d: got %b want %b", k, d_t9, exp9);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_zero();
        test_reset();
        test_all_zero();
        test_back_to_back();
        test_mask_off();
        test_full_mismatch();
        test_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instance5_unit.md
Name: instance5_unit

Overview:
- Four-lane masked-difference detector.
- Compares each byte lane of a 32-bit packed word against a reference byte `c` under a bit mask `b`.
- Counts the differing bits per lane and raises one registered flag per lane when that count reaches a threshold.
- Used as a leaf datapath block; it is built from lane submodules (XOR/mask, popcount, compare) instantiated four times.

Parameters:
- THRESHOLD, default 2: minimum masked mismatch count (0..9) that sets a lane flag. 0 means the flag is always set; 9 means it is never set.

Ports:
- clock    input   1       rising-edge clock; all state updates on this edge only.
- reset_n  input   1       synchronous active-low reset.
- a        input   [3:0][7:0]  four byte lanes; a[3] is the most significant byte.
- b        input   [0:7]   bit mask, big-endian declared; b[0] is the MSB position.
- c        input   [7:0]   reference byte.
- d        output  [0:3]   registered lane flags; d[0] is the MSB position.

Behaviour:
- Lane i (i = 0..3) combinational path:
  - m_i = (a[i] XOR c) AND b.
  - Operands align positionally, MSB to MSB: b[0] pairs with c[7] and a[i][7]; b[7] pairs with c[0] and a[i][0].
  - n_i = popcount(m_i), range 0..8, held in 4 bits.
  - f_i = (n_i >= THRESHOLD).
- Output mapping is positional MSB-first: d[0]=f_3, d[1]=f_2, d[2]=f_1, d[3]=f_0. Read as a 4-bit value, d = {f_3,f_2,f_1,f_0}.
- Latency: inputs sampled at rising edge N appear on d immediately after edge N. d is a flop; there is no combinational path from inputs to d.
- Reset:
  - At a rising edge with reset_n=0, d <= 4'b0000, overriding any lane result.
  - Reset asserted mid-stream clears d on that edge.
  - The first edge with reset_n=1 samples the current inputs normally.
- No handshake, no enable: d is recomputed every cycle.
- X on inputs propagates; no masking is required.
- All lanes are independent and evaluated in parallel. There is no wrap-around or saturation; n_i never exceeds 8.

Optional Feature:
- Macro INSTANCE5_PIPE_EN.
- Defined:
  - Adds a register stage holding the four n_i counts between popcount and compare.
  - Total latency becomes 2 edges (inputs at edge N, d valid after edge N+1).
  - Reset clears both the count registers and d.
- Undefined:
  - Single-stage design, 1-edge latency as above.

Test Plan:
- Reset: reset_n=0 for 2 edges with any inputs -> d=0000 after each edge. First edge after release samples inputs normally.
- All zero: a=32'h00000000, b=8'h00, c=8'h00 -> d=0000 after next edge.
- Mixed vector (THRESHOLD=2):
  - Inputs: a={8'hAC,8'h96,8'hF1,8'hA5}, b=8'hE7, c=8'h3C.
  - Expected counts: lane3=1, lane2=3, lane1=4, lane0=2.
  - Expected output: d=0111 one edge later.
  - Returning to all-zero inputs the next cycle gives d=0000 one edge after that.
- Mask off: b=8'h00 with the mixed a/c above -> all counts 0 -> d=0000; with THRESHOLD=0 build -> d=1111.
- Full mismatch: a=32'hFFFFFFFF, c=8'h00, b=8'hFF -> counts 8 -> d=1111; with THRESHOLD=9 build -> d=0000.
- INSTANCE5_PIPE_EN build: mixed vector applied one cycle only -> d=0111 exactly two edges after application, 0000 before and after.
